// File: rtl/mfp_ahb_master.sv
// mfp_ahb_master: single-outstanding AHB-lite initiator for the MFP system bus.
// Turns a valid/ready command into one NONSEQ transfer and reports the result
// on a one-cycle response strobe. All bus outputs come straight from flops.
module mfp_ahb_master #(
    parameter int unsigned TIMEOUT = 255,  // HREADY-low data cycles before abort; 0 = never
    parameter int unsigned TW      = 8     // wait counter width; TIMEOUT < 2**TW
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    // response side
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,

    // AHB-lite initiator
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0]    TransIdle   = 2'b00;
    localparam logic [1:0]    TransNonseq = 2'b10;
    localparam bit            TimeoutEn   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TimeoutVal  = TW'(TIMEOUT);
    localparam logic [TW-1:0] WaitMax     = '1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    state_e        state_q,   state_d;
    logic [31:0]   haddr_q,   haddr_d;
    logic [2:0]    hsize_q,   hsize_d;
    logic [1:0]    htrans_q,  htrans_d;
    logic          hwrite_q,  hwrite_d;
    logic [31:0]   hwdata_q,  hwdata_d;
    logic [31:0]   wdata_q,   wdata_d;    // write data held from accept to data phase
    logic [31:0]   rdata_q,   rdata_d;
    logic          err_q,     err_d;
    logic          tmo_q,     tmo_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    logic size_illegal;
    logic misaligned;

    // Command legality: only byte/half/word sizes, naturally aligned.
    always_comb begin
        size_illegal = (cmd_size > 3'd2);
        misaligned   = ((cmd_size == 3'd1) && cmd_addr[0]) ||
                       ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hsize_d    = hsize_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (cmd_valid) begin
                    if (size_illegal || misaligned) begin
                        // Rejected without touching the bus.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        haddr_d  = cmd_addr;
                        hsize_d  = cmd_size;
                        hwrite_d = cmd_write;
                        htrans_d = TransNonseq;
                        wdata_d  = cmd_wdata;
                        state_d  = StAddr;
                    end
                end
            end

            StAddr: begin
                if (HREADY) begin
                    htrans_d = TransIdle;
                    hwdata_d = hwrite_q ? wdata_q : 32'h0;
                    state_d  = StData;
                end
            end

            StData: begin
                if (HREADY) begin
                    if (!hwrite_q && !HRESP) begin
                        rdata_d = HRDATA;
                    end
                    err_d      = HRESP;
                    wait_cnt_d = '0;
                    state_d    = StResp;
                end else if (TimeoutEn && (wait_cnt_q == TimeoutVal)) begin
                    err_d      = 1'b1;
                    tmo_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StResp;
                end else if (wait_cnt_q != WaitMax) begin
                    // Saturate rather than wrap.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            StResp: begin
                // Status is only meaningful while rsp_valid is high.
                err_d   = 1'b0;
                tmo_d   = 1'b0;
                rdata_d = 32'h0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            haddr_q    <= 32'h0;
            hsize_q    <= 3'd0;
            htrans_q   <= TransIdle;
            hwrite_q   <= 1'b0;
            hwdata_q   <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hsize_q    <= hsize_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Handshake strobes decode directly from the state register.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

    assign HADDR     = haddr_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_mfp_ahb_master.sv
// Directed testbench for mfp_ahb_master; the bench plays the AHB slave by
// driving HREADY/HRESP/HRDATA step by step.
module tb_mfp_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int total = 0;
    int bad   = 0;

    mfp_ahb_master #(
        .TIMEOUT(4),
        .TW     (8)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_size   (cmd_size),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .HADDR      (HADDR),
        .HBURST     (HBURST),
        .HMASTLOCK  (HMASTLOCK),
        .HPROT      (HPROT),
        .HSIZE      (HSIZE),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
    endtask

    task automatic drop_cmd();
        // Scramble the command inputs to show they are only sampled at accept.
        cmd_valid = 1'b0;
        cmd_addr  = 32'h1234_5678;
        cmd_wdata = 32'hFFFF_0000;
        cmd_size  = 3'd0;
        cmd_write = ~cmd_write;
    endtask

    initial begin
        int acc [3];
        int nacc;
        logic rdy;

        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hsize", HSIZE, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("tie_hprot", HPROT, 4'b0011);
        chk("tie_hburst", HBURST, 0);
        chk("tie_hmastlock", HMASTLOCK, 0);
        HRESETn = 1'b1;
        tick();

        // ---- zero-wait word write
        issue(1'b1, 32'hBF80_0000, 3'd2, 32'h0000_A5A5);
        tick();  // accept edge N
        drop_cmd();
        chk("wr_htrans_nonseq", HTRANS, 2'b10);
        chk("wr_hwrite", HWRITE, 1);
        chk("wr_haddr", HADDR, 32'hBF80_0000);
        chk("wr_hsize", HSIZE, 2);
        chk("wr_cmd_ready_low", cmd_ready, 0);
        chk("wr_no_rsp_n", rsp_valid, 0);
        tick();  // N+1
        chk("wr_htrans_idle", HTRANS, 0);
        chk("wr_hwdata", HWDATA, 32'h0000_A5A5);
        chk("wr_no_rsp_n1", rsp_valid, 0);
        tick();  // N+2
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_ready_low_resp", cmd_ready, 0);
        tick();  // N+3
        chk("wr_rsp_drop", rsp_valid, 0);
        chk("wr_ready_back", cmd_ready, 1);

        // ---- read with 3 data-phase wait states
        issue(1'b0, 32'hBFC0_0010, 3'd2, 32'h0);
        tick();  // N
        drop_cmd();
        chk("rd_htrans_nonseq", HTRANS, 2'b10);
        chk("rd_hwrite", HWRITE, 0);
        tick();  // N+1, now in data phase
        chk("rd_htrans_idle", HTRANS, 0);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_wait_htrans", HTRANS, 0);
            chk("rd_wait_no_rsp", rsp_valid, 0);
        end
        HREADY = 1'b1;
        HRDATA = 32'h3C08_BF80;
        tick();  // N+5
        HRDATA = 32'h0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h3C08_BF80);
        chk("rd_rsp_err", rsp_err, 0);
        tick();
        chk("rd_rsp_drop", rsp_valid, 0);
        chk("rd_rdata_clear", rsp_rdata, 0);

        // ---- two-cycle error response
        issue(1'b0, 32'h8000_0004, 3'd2, 32'h0);
        tick();
        drop_cmd();
        tick();  // data phase
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        chk("err_wait_no_rsp", rsp_valid, 0);
        HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
        tick();
        HRESP = 1'b0; HRDATA = 32'h0;
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("err_rsp_rdata", rsp_rdata, 0);
        tick();
        chk("err_cleared", rsp_err, 0);

        // ---- misaligned word
        issue(1'b1, 32'h8000_0002, 3'd2, 32'h1111_1111);
        tick();
        drop_cmd();
        chk("mis_htrans", HTRANS, 0);
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_err", rsp_err, 1);
        tick();
        chk("mis_rsp_drop", rsp_valid, 0);
        chk("mis_ready", cmd_ready, 1);

        // ---- misaligned halfword
        issue(1'b0, 32'h8000_0001, 3'd1, 32'h0);
        tick();
        drop_cmd();
        chk("mish_htrans", HTRANS, 0);
        chk("mish_rsp_err", rsp_err, 1);
        tick();

        // ---- illegal size on an aligned address
        issue(1'b0, 32'h8000_0000, 3'd3, 32'h0);
        tick();
        drop_cmd();
        chk("size_htrans", HTRANS, 0);
        chk("size_rsp_valid", rsp_valid, 1);
        chk("size_rsp_err", rsp_err, 1);
        tick();

        // ---- aligned halfword at offset 2 is legal
        issue(1'b1, 32'h8000_0002, 3'd1, 32'hBEEF_0000);
        tick();
        drop_cmd();
        chk("half_htrans", HTRANS, 2'b10);
        chk("half_hsize", HSIZE, 1);
        tick();
        chk("half_hwdata", HWDATA, 32'hBEEF_0000);
        tick();
        chk("half_rsp_err", rsp_err, 0);
        tick();

        // ---- timeout: 4 counted waits, abort on the next low cycle
        issue(1'b0, 32'hBF80_0010, 3'd2, 32'h0);
        tick();
        drop_cmd();
        tick();  // data phase
        HREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo_waiting", rsp_valid, 0);
        end
        tick();
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_timeout", rsp_timeout, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        HREADY = 1'b1;
        tick();
        chk("tmo_ready_back", cmd_ready, 1);
        chk("tmo_flag_clear", rsp_timeout, 0);

        // ---- reset during the data phase
        issue(1'b1, 32'hBF80_0020, 3'd2, 32'hCAFE_F00D);
        tick();
        drop_cmd();
        tick();
        chk("rstd_hwdata_pre", HWDATA, 32'hCAFE_F00D);
        HREADY = 1'b0; HRESETn = 1'b0;
        tick();
        chk("rstd_htrans", HTRANS, 0);
        chk("rstd_ready", cmd_ready, 1);
        chk("rstd_no_rsp", rsp_valid, 0);
        chk("rstd_hwdata", HWDATA, 0);
        HRESETn = 1'b1; HREADY = 1'b1;
        tick();
        chk("rstd_still_no_rsp", rsp_valid, 0);

        // ---- back-to-back with cmd_valid held high
        issue(1'b1, 32'hBF80_0030, 3'd2, 32'h5555_AAAA);
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            rdy = cmd_ready;
            tick();
            if (rdy) begin
                if (nacc < 3) acc[nacc] = c;
                nacc++;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_accept_count", nacc, 3);
        chk("b2b_first", acc[0], 0);
        chk("b2b_gap1", acc[1] - acc[0], 4);
        chk("b2b_gap2", acc[2] - acc[1], 4);
        tick(); tick(); tick(); tick();
        chk("b2b_drained", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
